// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a stalled CPU MEM-stage access into a single bus transaction (IDLE/REQ/DONE).
// Optional bus timeout with sticky err_o when DMEM_TIMEOUT_EN is defined.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic        bus_req_reg;
  logic        bus_we_reg;
  logic [31:0] bus_addr_reg;
  logic [3:0]  bus_sel_reg;
  logic [31:0] bus_wdata_reg;
  logic [31:0] cpu_data_reg;
  logic        timeout_hit;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // Fires in the REQ cycle whose missing ack would make the count reach TIMEOUT_CYCLES.
  assign timeout_hit = (state_reg == REQ) && !bus_ack_i &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && cpu_ce_i) begin
        cnt_reg <= '0;
      end else if (state_reg == REQ && !bus_ack_i) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_o = err_reg;
`else
  // Without the timeout the bridge waits for ack forever; the parameter has no effect.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES < 1);
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_sel_reg   <= '0;
      bus_wdata_reg <= '0;
      cpu_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_ce_i) begin
            bus_we_reg    <= cpu_we_i;
            bus_addr_reg  <= cpu_addr_i;
            bus_sel_reg   <= cpu_sel_i;
            bus_wdata_reg <= cpu_data_i;
            bus_req_reg   <= 1'b1;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // An ack in the same cycle as the timeout wins.
          if (bus_ack_i) begin
            if (!bus_we_reg) begin
              cpu_data_reg <= bus_rdata_i;
            end
            bus_req_reg <= 1'b0;
            state_reg   <= DONE;
          end else if (timeout_hit) begin
            if (!bus_we_reg) begin
              cpu_data_reg <= 32'hDEADBEEF;
            end
            bus_req_reg <= 1'b0;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          bus_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign stallreq_o  = cpu_ce_i & (state_reg != DONE);
  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_sel_o   = bus_sel_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign cpu_data_o  = cpu_data_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus queues expected accesses, a negedge monitor checks bus and completion.
// Timeout cases run only when DMEM_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        err_o;

  dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_sel_o  (bus_sel_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i  (bus_ack_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks the held bus fields every REQ cycle and the result when the stall releases.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_cnt = 0;
      end else begin
        if (bus_req_o && sb.size() > 0) begin
          req_cnt++;
          check("bus_addr", bus_addr_o, sb[0].addr);
          check("bus_we", 32'(bus_we_o), 32'(sb[0].we));
          check("bus_sel", 32'(bus_sel_o), 32'(sb[0].sel));
          check("bus_wdata", bus_wdata_o, sb[0].wdata);
        end
        if (cpu_ce_i && !stallreq_o) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got completion expected none");
          end else begin
            e = sb.pop_front();
            check("cpu_data", cpu_data_o, e.data);
            check("err", 32'(err_o), 32'(e.err));
            check("req_cycles", 32'(req_cnt), 32'(e.reqs));
            check("req_dropped", 32'(bus_req_o), 32'd0);
            $display("access addr=%h we=%0d data=%h err=%0d req_cycles=%0d",
                     e.addr, e.we, cpu_data_o, err_o, req_cnt);
          end
          req_cnt = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b0;
    end
  endtask

  // ack_at: REQ-cycle index (0 = first REQ cycle) at which ack is given; 255 = never.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_reqs);
    exp_t e;
    int n;
    e.addr = addr; e.we = we; e.sel = sel; e.wdata = wdata;
    e.data = exp_data; e.err = exp_err; e.reqs = exp_reqs;
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    @(posedge clk); #1;
    n = 0;
    while (stallreq_o && n < 40) begin
      if (n == ack_at) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdata;
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      bus_rdata_i = 32'hBAD0BAD0;
      n++;
    end
    if (stallreq_o) begin
      total++;
      bad++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
    end
  endtask

  initial begin : stimulus
    rst = 1'b0;
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    bus_rdata_i = 32'hBAD0BAD0; bus_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_bus_we", 32'(bus_we_o), 32'd0);
    check("rst_bus_addr", bus_addr_o, 32'd0);
    check("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    check("rst_bus_wdata", bus_wdata_o, 32'd0);
    check("rst_cpu_data", cpu_data_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b1;

    // Ack while idle must be ignored.
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0BAD0;
    check("idle_ack_data", cpu_data_o, 32'd0);
    check("idle_ack_req", 32'(bus_req_o), 32'd0);

    // Read, ack in first REQ cycle.
    access(1'b0, 32'h100, 4'hF, 32'h0, 32'h12345678, 0, 32'h12345678, 1'b0, 1);
    idle(2);
    // Write with 3 wait states: read data unchanged.
    access(1'b1, 32'h204, 4'b0011, 32'hAABBCCDD, 32'h99999999, 3, 32'h12345678, 1'b0, 4);
    idle(1);
    // Back-to-back reads.
    access(1'b0, 32'h0, 4'hF, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 1);
    access(1'b0, 32'h4, 4'hF, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 1);
    // Read, 2 wait states, single lane.
    access(1'b0, 32'h3FC, 4'b1000, 32'h0, 32'h55AA33CC, 2, 32'h55AA33CC, 1'b0, 3);
    idle(1);

    // Reset in the middle of a pending read, then a late ack.
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF;
    @(posedge clk); #1;
    check("pend_req", 32'(bus_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req", 32'(bus_req_o), 32'd0);
    check("mid_rst_addr", bus_addr_o, 32'd0);
    check("mid_rst_data", cpu_data_o, 32'd0);
    rst = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h77777777;
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0BAD0;
    check("late_ack_data", cpu_data_o, 32'd0);
    check("late_ack_req", 32'(bus_req_o), 32'd0);

    // FSM still usable after reset.
    access(1'b0, 32'h8, 4'hF, 32'h0, 32'h11223344, 1, 32'h11223344, 1'b0, 2);
    idle(1);

`ifdef DMEM_TIMEOUT_EN
    // Ack in the 4th REQ cycle beats the timeout.
    access(1'b0, 32'h10, 4'hF, 32'h0, 32'h600D600D, 3, 32'h600D600D, 1'b0, 4);
    idle(1);
    // Never acked: aborted after 4 REQ cycles.
    access(1'b0, 32'h14, 4'hF, 32'h0, 32'h0, 255, 32'hDEADBEEF, 1'b1, 4);
    idle(1);
    // err_o stays set across a later normal access.
    access(1'b0, 32'h18, 4'hF, 32'h0, 32'h31415926, 0, 32'h31415926, 1'b1, 1);
    idle(1);
`endif

    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of bus wait cycles before an access is aborted (used only when DMEM_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (rst==0 resets on the next rising clk edge).
REQ-004 SHALL have port cpu_ce_i  input  1  CPU data-memory access enable, held stable while stalled.
REQ-005 SHALL have port cpu_we_i  input  1  write (1) or read (0).
REQ-006 SHALL have port cpu_addr_i  input  32  byte address.
REQ-007 SHALL have port cpu_sel_i  input  4  byte-lane select.
REQ-008 SHALL have port cpu_data_i  input  32  write data.
REQ-009 SHALL have port cpu_data_o  output  32  read data returned to the MEM stage.
REQ-010 SHALL have port stallreq_o  output  1  pipeline stall request to ctrl.
REQ-011 SHALL have ports bus_req_o  output  1 and bus_we_o  output  1, the bus request and write strobe.
REQ-012 SHALL have ports bus_addr_o  output  32, bus_sel_o  output  4 and bus_wdata_o  output  32, the latched access.
REQ-013 SHALL have ports bus_rdata_i  input  32 and bus_ack_i  input  1, the slave read data and one-cycle completion.
REQ-014 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-016 In IDLE, when cpu_ce_i==1, the block SHALL latch addr, we, sel and wdata into the bus_* registers and go to REQ.
REQ-017 In REQ, bus_req_o SHALL be 1 and all bus_* outputs SHALL be held constant.
REQ-018 In REQ, bus_ack_i==1 SHALL capture bus_rdata_i into cpu_data_o (reads only), deassert bus_req_o on the next cycle, and go to DONE.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-020 stallreq_o SHALL be combinational and equal cpu_ce_i & (state!=DONE).
REQ-021 The access latency SHALL be: ce seen in IDLE at cycle 0, bus_req_o high from cycle 1, ack at cycle k≥1, DONE and stall released at cycle k+1.
REQ-022 The minimum access SHALL therefore stall 2 cycles.
REQ-023 bus_ack_i SHALL be ignored in IDLE and DONE.
REQ-024 cpu_data_o SHALL hold its last captured value until the next read ack.
REQ-025 Writes SHALL leave cpu_data_o unchanged.
REQ-026 cpu_data_o SHALL carry the full bus word; lane extraction and sign extension SHALL remain in the MEM stage.
REQ-027 After DONE, cpu_ce_i==1 in IDLE SHALL start a new access.
REQ-028 The pipeline SHALL advance during DONE, so back-to-back accesses incur no extra idle cycle beyond the IDLE cycle.

Reset
REQ-029 On rst==0 at a clk edge, state SHALL go to IDLE.
REQ-030 On reset, bus_req_o, bus_we_o and err_o SHALL go to 0.
REQ-031 On reset, bus_addr_o, bus_sel_o, bus_wdata_o and cpu_data_o SHALL go to 0.
REQ-032 On reset, the timeout counter SHALL go to 0.
REQ-033 Reset mid-access SHALL abandon the access, dropping bus_req_o on that edge.
REQ-034 A bus_ack_i arriving after a reset SHALL be ignored.

Configuration
REQ-035 With macro DMEM_TIMEOUT_EN defined, a counter SHALL clear on entering REQ and increment each REQ cycle without ack.
REQ-036 With DMEM_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the block SHALL drop bus_req_o, load cpu_data_o=32'hDEADBEEF (reads), set err_o=1 (sticky until reset), and go to DONE.
REQ-037 With DMEM_TIMEOUT_EN defined, an ack in the same cycle as the count reaching TIMEOUT_CYCLES SHALL win, giving a normal completion with err_o unchanged.
REQ-038 With DMEM_TIMEOUT_EN undefined, REQ SHALL wait indefinitely for ack.
REQ-039 With DMEM_TIMEOUT_EN undefined, err_o SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-040 Read, ack in first REQ cycle: ce=1, we=0, addr=0x100, rdata=0x12345678 → bus_req_o high 1 cycle; stallreq_o high cycles 0–1, low cycle 2; cpu_data_o=0x12345678 at cycle 2.
REQ-041 Write with 3 wait states: we=1, addr=0x204, sel=4'b0011, wdata=0xAABBCCDD → bus_* stable 4 cycles; bus_req_o drops after ack; cpu_data_o unchanged.
REQ-042 Back-to-back reads 0x0 then 0x4, ack each in 1 cycle → two 3-cycle accesses separated by DONE; second read data correct.
REQ-043 Reset mid-access: rst=0 at cycle 2 of a pending read → next edge bus_req_o=0, state IDLE; a late ack leaves cpu_data_o=0.
REQ-044 Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4), never ack → bus_req_o drops after 4 REQ cycles; cpu_data_o=0xDEADBEEF; err_o=1 and stays 1.
REQ-045 Timeout race: ack in the 4th REQ cycle → normal data returned; err_o=0.
